// File: rtl/simd_muland_seq.sv
// Operation sequencer for the SIMD multiply/AND row unit: accepts a request, walks
// the y slices through the carry-save row, waits out the datapath, then hands off the result.
module simd_muland_seq #(
   parameter  int N_SLICE = 8,
   parameter  int DP_LAT  = 2,
   parameter  int CNT_W   = 16,
   localparam int SLICE_W = (N_SLICE > 1) ? $clog2(N_SLICE) : 1
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               req_valid_i,
   output logic               req_ready_o,
   input  logic               req_mode_b_i,
   input  logic [2:0]         req_width_i,
   output logic               dp_load_o,
   output logic               dp_clr_o,
   output logic               dp_step_o,
   output logic [SLICE_W-1:0] dp_slice_o,
   output logic               dp_mode_b_o,
   output logic [2:0]         dp_width_o,
   output logic               res_valid_o,
   output logic               res_err_o,
   input  logic               res_ready_i,
   output logic               busy_o,
   output logic [CNT_W-1:0]   op_cnt_o
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam int                 DRAIN_W     = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;
   localparam logic [SLICE_W-1:0] LAST_PASS_A = SLICE_W'(N_SLICE - 1);
   localparam logic [DRAIN_W-1:0] LAST_DRAIN  = DRAIN_W'((DP_LAT > 0) ? DP_LAT - 1 : 0);

   state_t             state_q, state_d;
   logic [SLICE_W-1:0] pass_q, pass_d;
   logic [DRAIN_W-1:0] drain_q, drain_d;
   logic               mode_b_q, mode_b_d;
   logic [2:0]         width_q, width_d;
   logic               err_q, err_d;
   logic [CNT_W-1:0]   op_cnt_q, op_cnt_d;

   logic width_ok;
   logic accept;
   logic last_pass;
   logic res_hs;

   // Only thermometer codes select a real lane width.
   assign width_ok  = (req_width_i == 3'b000) || (req_width_i == 3'b001) ||
                      (req_width_i == 3'b011) || (req_width_i == 3'b111);
   assign accept    = req_valid_i & req_ready_o;
   assign res_hs    = (state_q == DONE) & res_ready_i;
   assign last_pass = (pass_q == (mode_b_q ? {SLICE_W{1'b0}} : LAST_PASS_A));

   always_comb begin
      req_ready_o = 1'b0;
      dp_step_o   = 1'b0;
      res_valid_o = 1'b0;
      busy_o      = 1'b1;
      case (state_q)
         IDLE: begin
            req_ready_o = 1'b1;
            busy_o      = 1'b0;
         end
         RUN:   dp_step_o = 1'b1;
         DRAIN: ;
         DONE: begin
            req_ready_o = res_ready_i;
            res_valid_o = 1'b1;
         end
         default: ;
      endcase
      dp_load_o   = accept & width_ok;
      dp_clr_o    = dp_step_o & (pass_q == {SLICE_W{1'b0}});
      dp_slice_o  = dp_step_o ? pass_q : {SLICE_W{1'b0}};
      res_err_o   = res_valid_o & err_q;
      dp_mode_b_o = mode_b_q;
      dp_width_o  = width_q;
      op_cnt_o    = op_cnt_q;
   end

   always_comb begin
      state_d  = state_q;
      pass_d   = pass_q;
      drain_d  = drain_q;
      mode_b_d = mode_b_q;
      width_d  = width_q;
      err_d    = err_q;
      op_cnt_d = op_cnt_q;
      case (state_q)
         RUN: begin
            pass_d = pass_q + SLICE_W'(1);
            if (last_pass) begin
               pass_d  = {SLICE_W{1'b0}};
               drain_d = {DRAIN_W{1'b0}};
               state_d = (DP_LAT == 0) ? DONE : DRAIN;
            end
         end
         DRAIN: begin
            drain_d = drain_q + DRAIN_W'(1);
            if (drain_q == LAST_DRAIN) state_d = DONE;
         end
         DONE: if (res_ready_i) state_d = IDLE;
         default: ;
      endcase
      if (res_hs && !err_q) op_cnt_d = op_cnt_q + CNT_W'(1);
      // A new accept overrides the DONE->IDLE step so back-to-back ops have no gap.
      if (accept) begin
         mode_b_d = req_mode_b_i;
         width_d  = req_width_i;
         err_d    = ~width_ok;
         pass_d   = {SLICE_W{1'b0}};
         state_d  = width_ok ? RUN : DONE;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q  <= IDLE;
         pass_q   <= '0;
         drain_q  <= '0;
         mode_b_q <= 1'b0;
         width_q  <= 3'b000;
         err_q    <= 1'b0;
         op_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         pass_q   <= pass_d;
         drain_q  <= drain_d;
         mode_b_q <= mode_b_d;
         width_q  <= width_d;
         err_q    <= err_d;
         op_cnt_q <= op_cnt_d;
      end
   end

endmodule
